// File: rtl/fnd_scan_controller_if.sv
// Conversion request/result and 7-segment scan signals of the FND controller.
`timescale 1ns/1ps
interface fnd_scan_controller_if;
  logic        start;
  logic [11:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  com;
  logic [7:0]  seg_7;

  modport master (output start, bin, input busy, done, bcd, com, seg_7);
  modport slave  (input start, bin, output busy, done, bcd, com, seg_7);
endinterface

// File: rtl/fnd_scan_controller.sv
// 12-bit binary to 4-digit BCD converter (shift-add-3) driving a multiplexed
// 4-digit common-anode 7-segment display with optional leading-zero blanking.
`timescale 1ns/1ps
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic                   clk,
  input logic                   reset_p,
  fnd_scan_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(SCAN_DIV - 1);

  state_t      state_reg, state_next;
  logic [11:0] shift_reg, shift_next;
  logic [15:0] work_reg, work_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] bcd_reg, bcd_next;
  logic        done_reg, done_next;
  logic [15:0] work_adj;

  logic [CW-1:0] refresh_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    digit_zero;
  logic [3:0]    blank_mask;
  logic [3:0]    sel_nibble;
  logic [7:0]    seg_code;

  // Nibbles of 5 or more get +3 so the following shift carries into the next decade.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign work_adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] > 4'd4) ?
                                   work_reg[gi*4 +: 4] + 4'd3 :
                                   work_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      bcd_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      bcd_reg   <= bcd_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    bcd_next   = bcd_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shift_next = bus.bin;
          work_next  = '0;
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        work_next  = {work_adj[14:0], shift_reg[11]};
        shift_next = {shift_reg[10:0], 1'b0};
        cnt_next   = cnt_reg + 4'd1;
        if (cnt_reg == 4'd11) state_next = FINISH;
      end
      FINISH: begin
        bcd_next   = work_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.bcd  = bcd_reg;

  // Digit scan runs freely, unaffected by conversions in flight.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      refresh_reg <= '0;
      idx_reg     <= '0;
    end else if (refresh_reg == REFRESH_LAST) begin
      refresh_reg <= '0;
      idx_reg     <= idx_reg + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
    end
  end

  // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blank
      assign digit_zero[gi] = (bcd_reg[gi*4 +: 4] == 4'd0);
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = &digit_zero[3:gi];
      end
    end
  endgenerate

  assign sel_nibble = bcd_reg[{idx_reg, 2'b00} +: 4];

  always_comb begin
    seg_code = 8'hFF;
    case (sel_nibble)
      4'd0: seg_code = 8'b0000_0011;
      4'd1: seg_code = 8'b1001_1111;
      4'd2: seg_code = 8'b0010_0101;
      4'd3: seg_code = 8'b0000_1101;
      4'd4: seg_code = 8'b1001_1001;
      4'd5: seg_code = 8'b0100_1001;
      4'd6: seg_code = 8'b0100_0001;
      4'd7: seg_code = 8'b0001_1011;
      4'd8: seg_code = 8'b0000_0001;
      4'd9: seg_code = 8'b0001_1001;
      default: seg_code = 8'hFF;
    endcase
  end

  assign bus.com   = ~(4'b0001 << idx_reg);
  assign bus.seg_7 = (BLANK_LZ && blank_mask[idx_reg]) ? 8'hFF : seg_code;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: conversion results, latency, busy,
// digit scan/decode/blanking, ignored starts and reset abort.
`timescale 1ns/1ps
module tb_fnd_scan_controller;

  localparam int SCAN = 4;

  typedef struct {
    logic [15:0] bcd;
    int unsigned cyc;
  } exp_t;

  logic clk;
  logic reset_p;
  fnd_scan_controller_if bus_if();

  fnd_scan_controller #(.SCAN_DIV(SCAN), .BLANK_LZ(1'b1)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus_if)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned edge_cnt = 0;
  int unsigned scan_base = 0;
  logic [15:0] exp_disp = 16'h0000;
  exp_t        sb_q[$];
  int          pw[4] = '{1, 10, 100, 1000};
  logic [7:0]  seg_tab[10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                               8'h49, 8'h41, 8'h1B, 8'h01, 8'h19};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Output monitor: pops the scoreboard on each done pulse, flags unexpected or missing ones.
  always @(negedge clk) begin
    if (bus_if.done) begin
      if (sb_q.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        check_eq("done_latency", edge_cnt, sb_q[0].cyc);
        check_eq("done_bcd", {16'h0, bus_if.bcd}, {16'h0, sb_q[0].bcd});
        $display("txn: done bcd=%h at edge %0d", bus_if.bcd, edge_cnt);
        void'(sb_q.pop_front());
      end
    end else if (sb_q.size() != 0 && edge_cnt >= sb_q[0].cyc) begin
      check_eq("done_missing", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
  end

  // Called at a negedge while IDLE; returns at the negedge of the done cycle.
  task automatic run_conv(input int v);
    exp_t e;
    bus_if.start = 1'b1;
    bus_if.bin   = 12'(v);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.bin   = 12'($urandom);
    e.bcd = to_bcd(v);
    e.cyc = edge_cnt + 13;
    sb_q.push_back(e);
    $display("txn: start bin=%0d at edge %0d", v, edge_cnt);
    for (int i = 0; i < 13; i++) begin
      check_eq("busy_conv", {31'h0, bus_if.busy}, 32'd1);
      check_eq("bcd_hold", {16'h0, bus_if.bcd}, {16'h0, exp_disp});
      @(negedge clk);
    end
    check_eq("busy_idle", {31'h0, bus_if.busy}, 32'd0);
    exp_disp = to_bcd(v);
  endtask

  task automatic scan_check(input int cycles, input int v);
    for (int k = 0; k < cycles; k++) begin
      int         n;
      int         idx;
      int         dig;
      logic [3:0] ec;
      logic [7:0] es;
      n   = int'(edge_cnt - scan_base);
      idx = (n / SCAN) % 4;
      dig = (v / pw[idx]) % 10;
      ec  = ~(4'b0001 << idx);
      es  = (idx > 0 && v < pw[idx]) ? 8'hFF : seg_tab[dig];
      check_eq("scan_com", {28'h0, bus_if.com}, {28'h0, ec});
      check_eq("scan_seg", {24'h0, bus_if.seg_7}, {24'h0, es});
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset_p      = 1'b1;
    bus_if.start = 1'b0;
    bus_if.bin   = 12'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'h0, bus_if.busy}, 32'd0);
    check_eq("rst_done", {31'h0, bus_if.done}, 32'd0);
    check_eq("rst_bcd", {16'h0, bus_if.bcd}, 32'd0);
    check_eq("rst_com", {28'h0, bus_if.com}, 32'he);
    check_eq("rst_seg", {24'h0, bus_if.seg_7}, 32'h03);

    // Release and request on the very first edge after reset.
    reset_p   = 1'b0;
    scan_base = edge_cnt;
    run_conv(1234);
    check_eq("bcd_1234", {16'h0, bus_if.bcd}, 32'h1234);
    scan_check(20, 1234);

    // Back-to-back: each start lands in the IDLE cycle right after FINISH.
    run_conv(4095);
    run_conv(0);
    check_eq("bcd_zero", {16'h0, bus_if.bcd}, 32'h0);
    scan_check(16, 0);
    run_conv(7);
    scan_check(16, 7);
    run_conv(1007);
    scan_check(16, 1007);

    // Start while busy must be dropped.
    bus_if.start = 1'b1;
    bus_if.bin   = 12'd1234;
    @(negedge clk);
    bus_if.start = 1'b0;
    e.bcd = 16'h1234;
    e.cyc = edge_cnt + 13;
    sb_q.push_back(e);
    $display("txn: start bin=1234 at edge %0d, intruding start bin=55 at edge %0d", edge_cnt, edge_cnt + 5);
    for (int i = 0; i < 13; i++) begin
      bus_if.start = (i == 4);
      bus_if.bin   = (i == 4) ? 12'd55 : 12'd0;
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    check_eq("ignored_bcd", {16'h0, bus_if.bcd}, 32'h1234);
    repeat (16) @(negedge clk);
    exp_disp = 16'h1234;

    // Reset shortly before edge T+6 aborts the conversion.
    bus_if.start = 1'b1;
    bus_if.bin   = 12'd999;
    @(negedge clk);
    bus_if.start = 1'b0;
    e.bcd = 16'h0999;
    e.cyc = edge_cnt + 13;
    sb_q.push_back(e);
    $display("txn: start bin=999 at edge %0d, reset before edge %0d", edge_cnt, edge_cnt + 6);
    repeat (5) @(negedge clk);
    reset_p = 1'b1;
    sb_q.delete();
    #1;
    check_eq("abort_busy", {31'h0, bus_if.busy}, 32'd0);
    check_eq("abort_bcd", {16'h0, bus_if.bcd}, 32'h0);
    check_eq("abort_com", {28'h0, bus_if.com}, 32'he);
    check_eq("abort_seg", {24'h0, bus_if.seg_7}, 32'h03);
    @(negedge clk);
    reset_p   = 1'b0;
    scan_base = edge_cnt;
    exp_disp  = 16'h0000;
    repeat (20) @(negedge clk);
    check_eq("abort_bcd_after", {16'h0, bus_if.bcd}, 32'h0);
    check_eq("abort_busy_after", {31'h0, bus_if.busy}, 32'd0);

    run_conv(42);
    scan_check(16, 42);

    repeat (20) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
